// File: rtl/test_supervisor_if.sv
// Harness-facing bundle of the test supervisor: config and channel
// inputs from the harness, status back to it.
interface test_supervisor_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int NUM_CHAN    = 2,
  parameter int CNT_W       = 64,
  parameter int DLY_W       = 16
) ();
  localparam int CH_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  logic [CNT_W-1:0]             cfg_max_cycles;
  logic [NUM_DOMAINS*DLY_W-1:0] cfg_rst_delay;
  logic [NUM_CHAN-1:0]          chan_success;
  logic [NUM_CHAN-1:0]          chan_fail;
  logic [NUM_DOMAINS-1:0]       domain_reset;
  logic                         running;
  logic [CNT_W-1:0]             trace_count;
  logic                         done;
  logic                         pass;
  logic                         fail;
  logic [1:0]                   fail_reason;
  logic [CH_W-1:0]              fail_chan;

  modport master (
    output cfg_max_cycles, cfg_rst_delay,
    output chan_success, chan_fail,
    input  domain_reset, running, trace_count,
    input  done, pass, fail, fail_reason, fail_chan
  );

  modport slave (
    input  cfg_max_cycles, cfg_rst_delay,
    input  chan_success, chan_fail,
    output domain_reset, running, trace_count,
    output done, pass, fail, fail_reason, fail_chan
  );
endinterface

// File: rtl/test_supervisor.sv
// Test supervisor: staggered domain reset release, then run-cycle
// counting with channel pass/fail aggregation and timeout.
module test_supervisor #(
  parameter int NUM_DOMAINS = 3,
  parameter int NUM_CHAN    = 2,
  parameter int CNT_W       = 64,
  parameter int DLY_W       = 16
) (
  input logic               core_clock,
  input logic               reset,
  test_supervisor_if.slave  bus
);
  localparam int CH_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t                       r_state;
  logic [DLY_W-1:0]             r_seq_cnt;
  logic [CNT_W-1:0]             r_max;
  logic [NUM_DOMAINS*DLY_W-1:0] r_dly;
  logic [NUM_CHAN-1:0]          r_mask;
  logic [NUM_DOMAINS-1:0]       r_domain_reset;
  logic                         r_running;
  logic [CNT_W-1:0]             r_trace;
  logic                         r_done;
  logic                         r_pass;
  logic                         r_fail;
  logic [1:0]                   r_reason;
  logic [CH_W-1:0]              r_chan;

  logic [DLY_W-1:0]       w_seq_nxt;
  logic [NUM_DOMAINS-1:0] w_rel;
  logic [NUM_CHAN-1:0]    w_mask_nxt;
  logic [CH_W-1:0]        w_fail_idx;
  logic                   w_timeout;
  logic [CNT_W-1:0]       w_trace_nxt;

  assign w_seq_nxt   = (&r_seq_cnt) ? r_seq_cnt : r_seq_cnt + 1'b1;
  assign w_mask_nxt  = r_mask | bus.chan_success;
  assign w_timeout   = (r_max != '0) && (r_trace >= r_max);
  assign w_trace_nxt = (&r_trace) ? r_trace : r_trace + 1'b1;

  // w_seq_nxt is never 0, so a zero delay releases on edge 1
  always_comb begin
    w_rel = '0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      w_rel[i] = (w_seq_nxt >= r_dly[i*DLY_W +: DLY_W]);
  end

  always_comb begin
    w_fail_idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--)
      if (bus.chan_fail[i]) w_fail_idx = CH_W'(i);
  end

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      r_state        <= SEQ;
      r_seq_cnt      <= '0;
      r_max          <= bus.cfg_max_cycles;
      r_dly          <= bus.cfg_rst_delay;
      r_mask         <= '0;
      r_domain_reset <= '1;
      r_running      <= 1'b0;
      r_trace        <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_reason       <= 2'd0;
      r_chan         <= '0;
    end else begin
      unique case (r_state)
        SEQ: begin
          r_seq_cnt      <= w_seq_nxt;
          r_domain_reset <= r_domain_reset & ~w_rel;
          if (&w_rel) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          r_mask <= w_mask_nxt;
          if (|bus.chan_fail) begin
            r_state   <= FAIL;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
            r_reason  <= 2'd1;
            r_chan    <= w_fail_idx;
          end else if (w_timeout) begin
            r_state   <= FAIL;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_fail    <= 1'b1;
            r_reason  <= 2'd2;
          end else if (&w_mask_nxt) begin
            r_state   <= PASS;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b1;
          end else begin
            r_trace <= w_trace_nxt;
          end
        end
        PASS, FAIL: begin
          r_state <= r_state;
        end
        default: r_state <= SEQ;
      endcase
    end
  end

  assign bus.domain_reset = r_domain_reset;
  assign bus.running      = r_running;
  assign bus.trace_count  = r_trace;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.fail         = r_fail;
  assign bus.fail_reason  = r_reason;
  assign bus.fail_chan    = r_chan;
endmodule

// File: tb/tb_test_supervisor.sv
// Bench for test_supervisor: directed scenarios plus random runs,
// checked every cycle against a behavioural model.
module tb_test_supervisor;
  localparam int ND = 3;
  localparam int NC = 2;
  localparam int CW = 64;
  localparam int DW = 16;

  logic core_clock = 1'b0;
  logic reset = 1'b0;
  always #5 core_clock = ~core_clock;

  test_supervisor_if #(
    .NUM_DOMAINS(ND), .NUM_CHAN(NC), .CNT_W(CW), .DLY_W(DW)
  ) bus ();

  test_supervisor #(
    .NUM_DOMAINS(ND), .NUM_CHAN(NC), .CNT_W(CW), .DLY_W(DW)
  ) dut (
    .core_clock(core_clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  bit check_en = 0;
  int cyc = 0;

  // model: edges since reset release, plus run-phase results
  longint          m_edge = 0;
  longint          m_d[ND];
  longint          m_T = 1;
  longint unsigned m_max = 0;
  longint unsigned m_trace = 0;
  logic [NC-1:0]   m_mask = '0;
  bit              m_done = 0;
  bit              m_pass = 0;
  bit              m_fail = 0;
  int              m_reason = 0;
  int              m_chan = 0;

  always @(posedge core_clock) begin
    logic [NC-1:0] nm;
    cyc++;
    if (!reset) begin
      m_edge = 0;
      m_trace = 0;
      m_mask = '0;
      m_done = 0;
      m_pass = 0;
      m_fail = 0;
      m_reason = 0;
      m_chan = 0;
      m_max = bus.cfg_max_cycles;
      m_T = 1;
      for (int i = 0; i < ND; i++) begin
        m_d[i] = longint'(bus.cfg_rst_delay[i*DW +: DW]);
        if (m_d[i] > m_T) m_T = m_d[i];
      end
    end else begin
      m_edge++;
      if (!m_done && m_edge > m_T) begin
        nm = m_mask | bus.chan_success;
        if (bus.chan_fail != '0) begin
          m_done = 1;
          m_fail = 1;
          m_reason = 1;
          m_chan = 0;
          while (!bus.chan_fail[m_chan]) m_chan++;
        end else if (m_max != 0 && m_trace >= m_max) begin
          m_done = 1;
          m_fail = 1;
          m_reason = 2;
        end else if (&nm) begin
          m_done = 1;
          m_pass = 1;
        end else begin
          m_trace++;
        end
        m_mask = nm;
      end
    end
  end

  // per-cycle comparison against the model
  always @(posedge core_clock) begin
    logic [ND-1:0] e_dr;
    bit e_run;
    #1;
    if (check_en) begin
      for (int i = 0; i < ND; i++)
        e_dr[i] = !(m_edge >= ((m_d[i] == 0) ? 1 : m_d[i]));
      e_run = (m_edge >= m_T) && !m_done;
      total++;
      if (bus.domain_reset !== e_dr || bus.running !== e_run ||
          bus.trace_count !== m_trace || bus.done !== m_done ||
          bus.pass !== m_pass || bus.fail !== m_fail ||
          bus.fail_reason !== 2'(m_reason) ||
          bus.fail_chan !== 1'(m_chan)) begin
        bad++;
        $display("FAIL model cyc=%0d dr=%b/%b run=%b/%b tc=%0d/%0d done=%b/%b pass=%b/%b fail=%b/%b rsn=%0d/%0d ch=%0d/%0d",
          cyc, bus.domain_reset, e_dr, bus.running, e_run,
          bus.trace_count, m_trace, bus.done, m_done,
          bus.pass, m_pass, bus.fail, m_fail,
          bus.fail_reason, m_reason, bus.fail_chan, m_chan);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic apply_reset(int n, int d0, int d1, int d2,
                             longint unsigned mx);
    @(negedge core_clock);
    reset = 1'b0;
    bus.cfg_rst_delay = {DW'(d2), DW'(d1), DW'(d0)};
    bus.cfg_max_cycles = mx;
    bus.chan_success = '0;
    bus.chan_fail = '0;
    repeat (n) @(negedge core_clock);
    reset = 1'b1;
  endtask

  // returns at the negedge where the next edge is evaluated with trace==t
  task automatic wait_trace(longint unsigned t, string nm);
    int b = 2000;
    @(negedge core_clock);
    while (!(m_edge >= m_T && !m_done && m_trace == t) && b > 0) begin
      @(negedge core_clock);
      b--;
    end
    if (b == 0) chk({nm, "_wait_timeout"}, 1, 0);
  endtask

  task automatic wait_done(string nm);
    int b = 2000;
    while (!bus.done && b > 0) begin
      @(negedge core_clock);
      b--;
    end
    if (b == 0) chk({nm, "_done_timeout"}, 1, 0);
  endtask

  task automatic pulse(logic [NC-1:0] s, logic [NC-1:0] f);
    bus.chan_success = s;
    bus.chan_fail = f;
    @(negedge core_clock);
    bus.chan_success = '0;
    bus.chan_fail = '0;
  endtask

  initial begin
    bus.cfg_max_cycles = '0;
    bus.cfg_rst_delay = '0;
    bus.chan_success = '0;
    bus.chan_fail = '0;
    @(negedge core_clock);
    check_en = 1;

    // staggered release {5,0,12}
    apply_reset(2, 5, 0, 12, 0);
    for (int k = 1; k <= 13; k++) begin
      @(negedge core_clock);
      if (k == 1) chk("stag_e1_dr", bus.domain_reset, 3'b101);
      if (k == 4) chk("stag_e4_dr", bus.domain_reset, 3'b101);
      if (k == 5) chk("stag_e5_dr", bus.domain_reset, 3'b100);
      if (k == 11) chk("stag_e11_run", bus.running, 0);
      if (k == 12) chk("stag_e12_dr", bus.domain_reset, 3'b000);
      if (k == 12) chk("stag_e12_run", bus.running, 1);
    end

    // pass with sticky channels
    apply_reset(1, 1, 2, 3, 0);
    wait_trace(3, "pass_c3");
    pulse(2'b01, 2'b00);
    wait_trace(9, "pass_c9");
    pulse(2'b10, 2'b00);
    chk("pass_pass", bus.pass, 1);
    chk("pass_done", bus.done, 1);
    chk("pass_tc", bus.trace_count, 9);
    chk("pass_rsn", bus.fail_reason, 0);

    // timeout, then frozen under random inputs
    apply_reset(2, 2, 1, 0, 20);
    wait_done("tmo");
    chk("tmo_fail", bus.fail, 1);
    chk("tmo_rsn", bus.fail_reason, 2);
    chk("tmo_tc", bus.trace_count, 20);
    for (int k = 0; k < 50; k++) begin
      bus.chan_success = NC'($urandom);
      bus.chan_fail = NC'($urandom);
      bus.cfg_max_cycles = 64'($urandom);
      @(negedge core_clock);
    end
    chk("tmo_frz_tc", bus.trace_count, 20);
    chk("tmo_frz_rsn", bus.fail_reason, 2);
    chk("tmo_frz_run", bus.running, 0);

    // no timeout when limit is 0
    apply_reset(1, 0, 0, 0, 0);
    repeat (10000) @(negedge core_clock);
    chk("notmo_fail", bus.fail, 0);
    chk("notmo_run", bus.running, 1);

    // fail beats simultaneous final success
    apply_reset(1, 1, 1, 1, 0);
    wait_trace(2, "pri1_c2");
    pulse(2'b01, 2'b00);
    wait_trace(5, "pri1_c5");
    pulse(2'b10, 2'b10);
    chk("pri1_fail", bus.fail, 1);
    chk("pri1_rsn", bus.fail_reason, 1);
    chk("pri1_chan", bus.fail_chan, 1);

    // fail beats timeout
    apply_reset(1, 3, 1, 1, 6);
    wait_trace(6, "pri2_c6");
    pulse(2'b00, 2'b11);
    chk("pri2_rsn", bus.fail_reason, 1);
    chk("pri2_chan", bus.fail_chan, 0);

    // fail ignored while sequencing
    apply_reset(1, 4, 4, 4, 0);
    bus.chan_fail = 2'b11;
    wait_trace(0, "seqm_run");
    bus.chan_fail = 2'b00;
    wait_trace(4, "seqm_c4");
    pulse(2'b11, 2'b00);
    chk("seqm_pass", bus.pass, 1);
    chk("seqm_fail", bus.fail, 0);

    // config freeze and mid-run reset
    apply_reset(2, 1, 1, 1, 30);
    @(negedge core_clock);
    bus.cfg_max_cycles = 5;
    wait_trace(2, "mid_c2");
    pulse(2'b01, 2'b00);
    wait_trace(7, "mid_c7");
    chk("mid_nofail", bus.fail, 0);
    chk("mid_tc7", bus.trace_count, 7);
    reset = 1'b0;
    bus.cfg_max_cycles = 9;
    repeat (2) @(negedge core_clock);
    chk("mid_dr", bus.domain_reset, 3'b111);
    chk("mid_tc0", bus.trace_count, 0);
    reset = 1'b1;
    @(negedge core_clock);
    bus.cfg_max_cycles = 3;
    wait_trace(1, "mid_c1");
    pulse(2'b10, 2'b00);
    wait_done("mid");
    chk("mid_rsn", bus.fail_reason, 2);
    chk("mid_tc9", bus.trace_count, 9);

    // random runs
    for (int r = 0; r < 40; r++) begin
      longint unsigned mx;
      mx = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(40, 1);
      apply_reset($urandom_range(3, 1), $urandom_range(7, 0),
                  $urandom_range(7, 0), $urandom_range(7, 0), mx);
      for (int k = 0; k < 90; k++) begin
        @(negedge core_clock);
        reset = ($urandom_range(150, 0) != 0);
        bus.cfg_max_cycles = 64'($urandom_range(40, 0));
        for (int c = 0; c < NC; c++) begin
          bus.chan_success[c] = ($urandom_range(9, 0) == 0);
          bus.chan_fail[c] = ($urandom_range(59, 0) == 0);
        end
      end
    end

    @(negedge core_clock);
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
